// File: rtl/dummy_accelerator_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dummy_accelerator_arbiter
// Description : Round-robin arbiter sharing one accelerator between NumReq
//               requesters, with response routing, timeout and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module dummy_accelerator_arbiter #(
    parameter int NumReq        = 4,
    parameter int CtlWidth      = 8,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 256
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic [NumReq-1:0]             req_valid_i,
    output logic [NumReq-1:0]             req_ready_o,
    input  logic [NumReq*CtlWidth-1:0]    req_ctl_i,
    input  logic [NumReq*DataWidth-1:0]   req_data_i,
    output logic [NumReq-1:0]             rsp_valid_o,
    input  logic [NumReq-1:0]             rsp_ready_i,
    output logic [DataWidth-1:0]          rsp_data_o,
    output logic                          rsp_err_o,
    output logic                          acc_valid_o,
    input  logic                          acc_ready_i,
    output logic [CtlWidth-1:0]           acc_ctl_o,
    output logic [DataWidth-1:0]          acc_data_o,
    input  logic                          acc_rsp_valid_i,
    output logic                          acc_rsp_ready_o,
    input  logic [DataWidth-1:0]          acc_rsp_data_i,
    output logic                          acc_flush_o,
    output logic                          busy_o,
    output logic [$clog2(NumReq)-1:0]     grant_o
);

    localparam int C_GRANT_W = $clog2(NumReq);
    localparam int C_CNT_W   = $clog2(TimeoutCycles + 1);
    localparam logic [C_CNT_W-1:0]   C_CNT_LAST = C_CNT_W'(TimeoutCycles - 1);
    localparam logic [C_GRANT_W-1:0] C_LAST_IDX = C_GRANT_W'(NumReq - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        ERR_RSP  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [C_GRANT_W-1:0] grant_q, grant_d;
    logic [C_GRANT_W-1:0] ptr_q, ptr_d;
    logic [C_CNT_W-1:0]   cnt_q, cnt_d;

    logic                 w_found;
    logic [C_GRANT_W-1:0] w_pick;
    logic [C_GRANT_W-1:0] w_idx;
    logic [C_GRANT_W-1:0] w_ptr_next;
    logic                 w_rsp_hs;

    // Round-robin pick: first valid requester at or after ptr, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int i = 0; i < NumReq; i++) begin
            w_idx = C_GRANT_W'((int'(ptr_q) + i) % NumReq);
            if (!w_found && req_valid_i[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign w_ptr_next = (grant_q == C_LAST_IDX) ? '0 : grant_q + 1'b1;
    assign w_rsp_hs   = acc_rsp_valid_i & rsp_ready_i[grant_q];
    assign busy_o     = (state_q != IDLE);
    assign grant_o    = grant_q;

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        ptr_d           = ptr_q;
        cnt_d           = '0;
        req_ready_o     = '0;
        rsp_valid_o     = '0;
        rsp_data_o      = '0;
        rsp_err_o       = 1'b0;
        acc_valid_o     = 1'b0;
        acc_ctl_o       = '0;
        acc_data_o      = '0;
        acc_rsp_ready_o = 1'b0;
        acc_flush_o     = 1'b0;

        // Response path is a straight pass-through so a zero-latency
        // accelerator can complete in the ISSUE cycle itself.
        if (state_q == ISSUE || state_q == WAIT_RSP) begin
            rsp_valid_o[grant_q] = acc_rsp_valid_i;
            acc_rsp_ready_o      = rsp_ready_i[grant_q];
            rsp_data_o           = acc_rsp_data_i;
        end

        case (state_q)
            IDLE: begin
                if (w_found) begin
                    grant_d = w_pick;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                acc_valid_o          = 1'b1;
                acc_ctl_o            = req_ctl_i[int'(grant_q)*CtlWidth +: CtlWidth];
                acc_data_o           = req_data_i[int'(grant_q)*DataWidth +: DataWidth];
                req_ready_o[grant_q] = acc_ready_i;
                if (acc_ready_i && w_rsp_hs) begin
                    state_d = IDLE;
                    ptr_d   = w_ptr_next;
                end else if (acc_ready_i) begin
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (w_rsp_hs) begin
                    state_d = IDLE;
                    ptr_d   = w_ptr_next;
                end else if (cnt_q == C_CNT_LAST) begin
                    state_d     = ERR_RSP;
                    acc_flush_o = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ERR_RSP: begin
                rsp_valid_o[grant_q] = 1'b1;
                rsp_err_o            = 1'b1;
                if (rsp_ready_i[grant_q]) begin
                    state_d = IDLE;
                    ptr_d   = w_ptr_next;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flush aborts everything; no handshake may complete in that cycle.
        if (flush_i) begin
            state_d         = IDLE;
            grant_d         = grant_q;
            ptr_d           = ptr_q;
            cnt_d           = '0;
            acc_flush_o     = 1'b1;
            acc_valid_o     = 1'b0;
            req_ready_o     = '0;
            rsp_valid_o     = '0;
            rsp_err_o       = 1'b0;
            acc_rsp_ready_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dummy_accelerator_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dummy_accelerator_arbiter
// Description : Cycle-by-cycle vector table plus a bounded timeout sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dummy_accelerator_arbiter;

    localparam int N  = 4;
    localparam int CW = 8;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_i, flush_i;
    logic [N-1:0]    req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
    logic [N*CW-1:0] req_ctl_i;
    logic [N*DW-1:0] req_data_i;
    logic [DW-1:0]   rsp_data_o, acc_data_o, acc_rsp_data_i;
    logic [CW-1:0]   acc_ctl_o;
    logic            rsp_err_o, acc_valid_o, acc_ready_i, acc_rsp_valid_i;
    logic            acc_rsp_ready_o, acc_flush_o, busy_o;
    logic [1:0]      grant_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dummy_accelerator_arbiter #(
        .NumReq(N), .CtlWidth(CW), .DataWidth(DW), .TimeoutCycles(8)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_ctl_i(req_ctl_i), .req_data_i(req_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .acc_valid_o(acc_valid_o), .acc_ready_i(acc_ready_i),
        .acc_ctl_o(acc_ctl_o), .acc_data_o(acc_data_o),
        .acc_rsp_valid_i(acc_rsp_valid_i), .acc_rsp_ready_o(acc_rsp_ready_o),
        .acc_rsp_data_i(acc_rsp_data_i), .acc_flush_o(acc_flush_o),
        .busy_o(busy_o), .grant_o(grant_o)
    );

    typedef struct {
        logic        rst, fls;
        logic [3:0]  rv, rr;
        logic        ar, av;
        logic [31:0] ad;
        logic        busy;
        logic [1:0]  g;
        logic [3:0]  rdy, rspv;
        logic        accv, afl, err, arr;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [7:0] ctl_pat(input int i);
        return (i == 2) ? 8'd5 : 8'(8'h10 + i);
    endfunction

    function automatic logic [31:0] data_pat(input int i);
        return 32'hD000_0000 + 32'(i);
    endfunction

    task automatic add(input logic rst, fls, input logic [3:0] rv, rr,
                       input logic ar, av, input logic [31:0] ad,
                       input logic busy, input logic [1:0] g,
                       input logic [3:0] rdy, rspv,
                       input logic accv, afl, err, arr,
                       input logic [31:0] rdata);
        vec_t v;
        v.rst = rst; v.fls = fls; v.rv = rv; v.rr = rr; v.ar = ar; v.av = av;
        v.ad = ad; v.busy = busy; v.g = g; v.rdy = rdy; v.rspv = rspv;
        v.accv = accv; v.afl = afl; v.err = err; v.arr = arr; v.rdata = rdata;
        vecs.push_back(v);
    endtask

    // Idle cycle: nothing asserted, grant_o shows the last granted index.
    task automatic idle(input logic [3:0] rv, input logic [1:0] g);
        add(0, 0, rv, 4'b0000, 0, 0, 0, 0, g, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (row %0d): got %h, expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive_idle_inputs();
        rst_i = 0; flush_i = 0; req_valid_i = 0; rsp_ready_i = 0;
        acc_ready_i = 0; acc_rsp_valid_i = 0; acc_rsp_data_i = 0;
    endtask

    initial begin
        int n;
        logic seen;
        for (int i = 0; i < N; i++) begin
            req_ctl_i[i*CW +: CW]  = ctl_pat(i);
            req_data_i[i*DW +: DW] = data_pat(i);
        end
        drive_idle_inputs();
        rst_i = 1;
        repeat (2) @(negedge clk);

        // Reset state, then all four requesting with 1-cycle responses
        idle(4'b0000, 0);
        idle(4'b1111, 0);
        add(0,0,4'b1111,4'b1111,1,1,32'h11, 1,0,4'b0001,4'b0001,1,0,0,1,32'h11);
        idle(4'b1111, 0);
        add(0,0,4'b1111,4'b1111,1,1,32'h22, 1,1,4'b0010,4'b0010,1,0,0,1,32'h22);
        idle(4'b1111, 1);
        add(0,0,4'b1111,4'b1111,1,1,32'h33, 1,2,4'b0100,4'b0100,1,0,0,1,32'h33);
        idle(4'b1111, 2);
        add(0,0,4'b1111,4'b1111,1,1,32'h44, 1,3,4'b1000,4'b1000,1,0,0,1,32'h44);
        idle(4'b1111, 3);
        add(0,0,4'b1111,4'b1111,1,1,32'h55, 1,0,4'b0001,4'b0001,1,0,0,1,32'h55);
        // Req0 alone with ptr at 1 (wrap), zero-latency response 0xA5
        idle(4'b0001, 0);
        add(0,0,4'b0001,4'b1111,1,1,32'hA5, 1,0,4'b0001,4'b0001,1,0,0,1,32'hA5);
        idle(4'b0000, 0);
        // Req2: stall in ISSUE, accept, 5 waiting cycles, then response
        idle(4'b0100, 0);
        add(0,0,4'b0100,4'b0000,0,0,0, 1,2,4'b0000,4'b0000,1,0,0,0,0);
        add(0,0,4'b0100,4'b0000,1,0,0, 1,2,4'b0100,4'b0000,1,0,0,0,0);
        for (int k = 0; k < 5; k++)
            add(0,0,4'b0000,4'b0000,0,0,0, 1,2,4'b0000,4'b0000,0,0,0,0,0);
        add(0,0,4'b0000,4'b0100,0,1,32'h77, 1,2,4'b0000,4'b0100,0,0,0,1,32'h77);
        // ptr must now be 3
        idle(4'b1111, 2);
        add(0,0,4'b1111,4'b1111,1,1,32'h88, 1,3,4'b1000,4'b1000,1,0,0,1,32'h88);
        // Timeout: req1 accepted, 8 WAIT cycles, flush pulse on the 8th
        idle(4'b0010, 3);
        add(0,0,4'b0010,4'b0000,1,0,0, 1,1,4'b0010,4'b0000,1,0,0,0,0);
        for (int k = 0; k < 7; k++)
            add(0,0,4'b0000,4'b0000,0,0,0, 1,1,4'b0000,4'b0000,0,0,0,0,0);
        add(0,0,4'b0000,4'b0000,0,0,0, 1,1,4'b0000,4'b0000,0,1,0,0,0);
        add(0,0,4'b0000,4'b0000,0,1,32'hFF, 1,1,4'b0000,4'b0010,0,0,1,0,0);
        add(0,0,4'b0000,4'b0010,0,1,32'hFF, 1,1,4'b0000,4'b0010,0,0,1,0,0);
        idle(4'b0000, 1);
        // Flush in WAIT_RSP keeps ptr at 2
        idle(4'b1000, 1);
        add(0,0,4'b1000,4'b0000,1,0,0, 1,3,4'b1000,4'b0000,1,0,0,0,0);
        add(0,0,4'b0000,4'b0000,0,0,0, 1,3,4'b0000,4'b0000,0,0,0,0,0);
        add(0,1,4'b0000,4'b0000,0,0,0, 1,3,4'b0000,4'b0000,0,1,0,0,0);
        idle(4'b0110, 3);
        add(0,0,4'b0110,4'b1111,1,1,32'h99, 1,2,4'b0100,4'b0100,1,0,0,1,32'h99);
        idle(4'b0000, 2);
        // Reset during ISSUE: dropped, grant 0, re-arbitrate from index 0
        idle(4'b0010, 2);
        add(1,0,4'b0010,4'b0000,0,0,0, 1,1,4'b0000,4'b0000,1,0,0,0,0);
        idle(4'b1010, 0);
        add(0,0,4'b1010,4'b1111,1,1,32'h12, 1,1,4'b0010,4'b0010,1,0,0,1,32'h12);
        idle(4'b0000, 1);

        foreach (vecs[r]) begin
            vec_t v;
            v = vecs[r];
            @(negedge clk);
            rst_i = v.rst; flush_i = v.fls; req_valid_i = v.rv; rsp_ready_i = v.rr;
            acc_ready_i = v.ar; acc_rsp_valid_i = v.av; acc_rsp_data_i = v.ad;
            #1;
            chk("busy_o",          r, 32'(busy_o),          32'(v.busy));
            chk("grant_o",         r, 32'(grant_o),         32'(v.g));
            chk("req_ready_o",     r, 32'(req_ready_o),     32'(v.rdy));
            chk("rsp_valid_o",     r, 32'(rsp_valid_o),     32'(v.rspv));
            chk("acc_valid_o",     r, 32'(acc_valid_o),     32'(v.accv));
            chk("acc_flush_o",     r, 32'(acc_flush_o),     32'(v.afl));
            chk("rsp_err_o",       r, 32'(rsp_err_o),       32'(v.err));
            chk("acc_rsp_ready_o", r, 32'(acc_rsp_ready_o), 32'(v.arr));
            chk("rsp_data_o",      r, rsp_data_o,           v.rdata);
            chk("acc_ctl_o",       r, 32'(acc_ctl_o),  v.accv ? 32'(ctl_pat(int'(v.g))) : 32'h0);
            chk("acc_data_o",      r, acc_data_o,      v.accv ? data_pat(int'(v.g)) : 32'h0);
        end

        // Bounded timeout measurement: ptr is 2, so req0 wins by wrap-around
        @(negedge clk); drive_idle_inputs(); req_valid_i = 4'b0001; #1;
        @(negedge clk); acc_ready_i = 1; #1;
        chk("seq_acc_valid", -1, 32'(acc_valid_o), 32'h1);
        chk("seq_grant",     -1, 32'(grant_o),     32'h0);
        chk("seq_acc_ctl",   -1, 32'(acc_ctl_o),   32'(ctl_pat(0)));
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk); drive_idle_inputs(); #1;
            n++;
            seen = acc_flush_o;
        end
        chk("seq_flush_seen",  -1, 32'(seen), 32'h1);
        chk("seq_wait_cycles", -1, 32'(n),    32'd8);
        @(negedge clk); rsp_ready_i = 4'b0001; #1;
        chk("seq_err",       -1, 32'(rsp_err_o),   32'h1);
        chk("seq_err_valid", -1, 32'(rsp_valid_o), 32'h1);
        chk("seq_err_data",  -1, rsp_data_o,       32'h0);
        @(negedge clk); drive_idle_inputs(); #1;
        chk("seq_idle", -1, 32'(busy_o), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
